ex_mem_stage_buffer: RTL and testbench
======================================

Name: ex_mem_stage_buffer

Overview:
- Receiving end of the execution-stage output bundle: alu_data, memory_data, overflow_flag, zero_flag, control_out, compflg_out, instr_valid.
- Captures each valid EX result into a small in-order FIFO and presents it to the memory stage with a valid/ready handshake. This decouples EX from MEM stalls.
- Also provides a pipeline flush, a sticky overflow indicator, and a retired-result counter for the scoreboard and for debug.

Parameters:
- DATA_W, 32: width of the alu_data and memory_data paths.
- DEPTH, 2: number of FIFO entries; must be a power of two, >= 2.
- CNT_W, 16: width of retire_count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high (sampled on clk only).
- flush  in  1  synchronous pipeline flush.
- ex_valid  in  1  EX result valid (instr_valid from EX).
- ex_alu_data  in  DATA_W  ALU result.
- ex_memory_data  in  DATA_W  store data.
- ex_overflow_flag  in  1  ALU overflow.
- ex_zero_flag  in  1  ALU zero.
- ex_control  in  control_type  control word (common package); carried opaquely.
- ex_compflg  in  1  compare flag.
- ex_ready  out  1  buffer can accept.
- mem_valid  out  1  head entry valid.
- mem_alu_data, mem_memory_data  out  DATA_W  head entry data.
- mem_overflow_flag, mem_zero_flag, mem_compflg  out  1  head entry flags.
- mem_control  out  control_type  head entry control word.
- mem_ready  in  1  memory stage accepts.
- ovf_clear  in  1  clears ovf_sticky.
- ovf_sticky  out  1  an overflowing result has been delivered.
- occupancy  out  $clog2(DEPTH+1)  current entry count.
- retire_count  out  CNT_W  number of results delivered.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst is synchronous and active-high. On reset: occupancy=0, read/write pointers=0, mem_valid=0, ovf_sticky=0, retire_count=0, ex_ready=1.
  - Storage array contents are not reset.
- Output gating: all mem_* data, flag and control outputs are forced to 0 whenever mem_valid=0, including immediately after reset.
- Push: occurs when ex_valid && ex_ready. The full field tuple is written at the write pointer and the pointer increments modulo DEPTH.
- Pop: occurs when mem_valid && mem_ready. The read pointer increments modulo DEPTH.
- Status signals:
  - ex_ready = (occupancy < DEPTH), derived from registered state only; no combinational path from mem_ready.
  - mem_valid = (occupancy != 0).
  - mem_* outputs show the entry at the read pointer.
- Latency: 1 cycle. A result pushed at edge N is visible on mem_* after edge N. There is no same-cycle bypass.
- Simultaneous push and pop (0 < occupancy < DEPTH): occupancy is unchanged and both pointers advance.
- Full (occupancy=DEPTH): ex_ready=0 and ex_valid is ignored. EX must hold its data. A pop in that cycle frees a slot, and ex_ready rises in the next cycle.
- Empty: mem_ready is ignored and no pop occurs.
- Order: strict FIFO; no reordering or dropping except on flush.
- Flush:
  - Takes priority over push and pop. In the flush cycle: occupancy=0, both pointers=0, mem_valid=0 next cycle.
  - ex_valid presented in the flush cycle is discarded.
  - A handshake with mem_valid && mem_ready in the flush cycle does not count as a pop: no retire_count increment and no ovf_sticky update.
  - Flush does not clear ovf_sticky or retire_count.
- rst versus flush: rst has priority over flush.
- ovf_sticky:
  - Set on a pop whose entry has overflow_flag=1.
  - Cleared by ovf_clear.
  - If set and clear occur in the same cycle, set wins (result is 1).
- retire_count: increments by 1 per non-flushed pop and wraps from 2^CNT_W-1 to 0.
- occupancy: always equals pushes minus pops since the last reset or flush, and never exceeds DEPTH.

Test Plan:
- Reset check: assert rst for 2 cycles with ex_valid=1 -> mem_valid=0, all mem_* outputs=0, ex_ready=1, occupancy=0, retire_count=0.
- Single transfer: push alu=0x0000_00AA, memory_data=0x1234_5678, zero=1, mem_ready=1 -> mem_valid=1 one cycle later with the same values; retire_count=1; occupancy returns to 0.
- Backpressure: mem_ready=0, push 0x11, 0x22, 0x33 on consecutive cycles -> 0x11 and 0x22 accepted, ex_ready=0 while 0x33 is held; raise mem_ready -> delivery order 0x11, 0x22, 0x33; retire_count=3.
- Flush: occupancy=2 and ex_valid=1 in the flush cycle -> next cycle occupancy=0, mem_valid=0; the pushed item never appears; retire_count unchanged.
- Overflow sticky: deliver an entry with overflow_flag=1 while ovf_clear=1 in the same cycle -> ovf_sticky=1; pulse ovf_clear alone -> 0; a flush does not clear it.
- Counter wrap: CNT_W=4, deliver 17 results -> retire_count=1.

Source files
------------

// File: rtl/ex_mem_stage_buffer.sv
// EX->MEM stage buffer: captures valid EX results in a small in-order FIFO and
// hands them to MEM with valid/ready, plus flush, sticky overflow and retire count.
module ex_mem_stage_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16,
  parameter int CTRL_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           ex_valid,
  input  logic [DATA_W-1:0]              ex_alu_data,
  input  logic [DATA_W-1:0]              ex_memory_data,
  input  logic                           ex_overflow_flag,
  input  logic                           ex_zero_flag,
  input  logic [CTRL_W-1:0]              ex_control,
  input  logic                           ex_compflg,
  output logic                           ex_ready,
  output logic                           mem_valid,
  output logic [DATA_W-1:0]              mem_alu_data,
  output logic [DATA_W-1:0]              mem_memory_data,
  output logic                           mem_overflow_flag,
  output logic                           mem_zero_flag,
  output logic                           mem_compflg,
  output logic [CTRL_W-1:0]              mem_control,
  input  logic                           mem_ready,
  input  logic                           ovf_clear,
  output logic                           ovf_sticky,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic [CNT_W-1:0]               retire_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int ENT_W = 2 * DATA_W + CTRL_W + 3;

  logic [ENT_W-1:0] fifo_q [DEPTH];
  logic [ENT_W-1:0] ex_entry, head_entry;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_en, pop_en;

  // Status comes from registered occupancy only, so ex_ready never sees mem_ready.
  assign ex_ready  = (occ_q < OCC_W'(DEPTH));
  assign mem_valid = (occ_q != '0);

  assign push_en = ex_valid & ex_ready & ~flush;
  assign pop_en  = mem_valid & mem_ready & ~flush;

  assign ex_entry   = {ex_alu_data, ex_memory_data, ex_control,
                       ex_overflow_flag, ex_zero_flag, ex_compflg};
  assign head_entry = fifo_q[rd_ptr_q];

  assign {mem_alu_data, mem_memory_data, mem_control,
          mem_overflow_flag, mem_zero_flag, mem_compflg} = mem_valid ? head_entry : '0;

  // Entry storage is deliberately left unreset; outputs are gated by mem_valid.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push_en && (wr_ptr_q == PTR_W'(gi))) begin
        fifo_q[gi] <= ex_entry;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // A delivered overflow beats a coincident clear.
  always_comb begin
    ovf_d = ovf_q;
    if (pop_en && head_entry[2]) begin
      ovf_d = 1'b1;
    end else if (ovf_clear) begin
      ovf_d = 1'b0;
    end
    cnt_d = cnt_q + CNT_W'(pop_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign occupancy    = occ_q;
  assign ovf_sticky   = ovf_q;
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_ex_mem_stage_buffer.sv
// Randomised and directed bench for ex_mem_stage_buffer against a queue-based
// reference model of the buffer's delivery, flush, sticky-overflow and counter rules.
module tb_ex_mem_stage_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 4;
  localparam int CTRL_W = 8;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] md;
    logic [7:0]  ctrl;
    logic        ovf;
    logic        zero;
    logic        cmp;
  } ent_t;

  logic clk = 1'b0;
  logic rst, flush, ex_valid, ex_overflow_flag, ex_zero_flag, ex_compflg;
  logic [DATA_W-1:0] ex_alu_data, ex_memory_data;
  logic [CTRL_W-1:0] ex_control;
  logic ex_ready, mem_valid, mem_overflow_flag, mem_zero_flag, mem_compflg;
  logic [DATA_W-1:0] mem_alu_data, mem_memory_data;
  logic [CTRL_W-1:0] mem_control;
  logic mem_ready, ovf_clear, ovf_sticky;
  logic [1:0] occupancy;
  logic [CNT_W-1:0] retire_count;
  logic [74:0] dut_head;

  ex_mem_stage_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .CTRL_W(CTRL_W)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_data(ex_alu_data), .ex_memory_data(ex_memory_data),
    .ex_overflow_flag(ex_overflow_flag), .ex_zero_flag(ex_zero_flag),
    .ex_control(ex_control), .ex_compflg(ex_compflg), .ex_ready(ex_ready),
    .mem_valid(mem_valid), .mem_alu_data(mem_alu_data), .mem_memory_data(mem_memory_data),
    .mem_overflow_flag(mem_overflow_flag), .mem_zero_flag(mem_zero_flag),
    .mem_compflg(mem_compflg), .mem_control(mem_control), .mem_ready(mem_ready),
    .ovf_clear(ovf_clear), .ovf_sticky(ovf_sticky), .occupancy(occupancy),
    .retire_count(retire_count)
  );

  assign dut_head = {mem_alu_data, mem_memory_data, mem_control,
                     mem_overflow_flag, mem_zero_flag, mem_compflg};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer is simply an ordered list of pending results.
  ent_t        mq[$];
  int unsigned m_cnt = 0;
  logic        m_ovf = 1'b0;

  function automatic ent_t exp_head();
    ent_t z = '0;
    return (mq.size() != 0) ? mq[0] : z;
  endfunction

  function automatic ent_t mk(logic [31:0] alu, logic [31:0] md, logic ovf, logic zero);
    ent_t e;
    e.alu = alu; e.md = md; e.ovf = ovf; e.zero = zero;
    e.ctrl = 8'($urandom); e.cmp = 1'($urandom);
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    return mk($urandom, $urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom));
  endfunction

  task automatic drive(ent_t e, logic v);
    ex_valid = v;
    ex_alu_data = e.alu; ex_memory_data = e.md; ex_control = e.ctrl;
    ex_overflow_flag = e.ovf; ex_zero_flag = e.zero; ex_compflg = e.cmp;
  endtask

  // Apply one clock of the model from the current inputs, then advance the DUT.
  task automatic tick();
    ent_t in_e, out_e;
    bit   do_pop, do_push;
    in_e = {ex_alu_data, ex_memory_data, ex_control, ex_overflow_flag, ex_zero_flag, ex_compflg};
    if (rst) begin
      mq.delete(); m_cnt = 0; m_ovf = 1'b0;
    end else if (flush) begin
      mq.delete();
      if (ovf_clear) m_ovf = 1'b0;
    end else begin
      do_pop  = (mq.size() != 0) && mem_ready;
      do_push = ex_valid && (mq.size() < DEPTH);
      if (do_pop) begin
        out_e = mq.pop_front();
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        $display("[%0t] deliver alu=%08h md=%08h ovf=%0b zero=%0b retired=%0d",
                 $time, out_e.alu, out_e.md, out_e.ovf, out_e.zero, m_cnt);
      end
      if (do_pop && out_e.ovf) m_ovf = 1'b1;
      else if (ovf_clear) m_ovf = 1'b0;
      if (do_push) mq.push_back(in_e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; mem_ready = 1'b1; ovf_clear = 1'b0;
    drive(rnd_ent(), 1'b1);
    tick(); tick();
    rst = 1'b0;
    drive('0, 1'b0);
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got=%0b exp=0", mem_valid); end
    checks++; if (dut_head !== '0) begin errors++; $display("FAIL reset_mem_outputs got=%h exp=0", dut_head); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready got=%0b exp=1", ex_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (retire_count !== '0) begin errors++; $display("FAIL reset_retire got=%0d exp=0", retire_count); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", ovf_sticky); end
    $display("[%0t] reset done", $time);
  endtask

  task automatic test_single();
    ent_t e;
    e = mk(32'h0000_00AA, 32'h1234_5678, 1'b0, 1'b1);
    mem_ready = 1'b1;
    drive(e, 1'b1);
    tick();
    drive('0, 1'b0);
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", mem_valid); end
    checks++; if (dut_head !== 75'(e)) begin errors++; $display("FAIL single_data got=%h exp=%h", dut_head, e); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL single_occ got=%0d exp=1", occupancy); end
    tick();
    checks++; if (retire_count !== 4'd1) begin errors++; $display("FAIL single_retire got=%0d exp=1", retire_count); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL single_occ_after got=%0d exp=0", occupancy); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after got=%0b exp=0", mem_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    logic [31:0] want[3];
    bit acc;
    want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33;
    mem_ready = 1'b0;
    drive(mk(32'h11, $urandom, 1'b0, 1'b0), 1'b1); tick();
    drive(mk(32'h22, $urandom, 1'b0, 1'b0), 1'b1); tick();
    drive(mk(32'h33, $urandom, 1'b0, 1'b0), 1'b1);
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%0b exp=0", ex_ready); end
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_full_occ got=%0d exp=2", occupancy); end
    tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_hold_occ got=%0d exp=2", occupancy); end
    checks++; if (mem_alu_data !== 32'h11) begin errors++; $display("FAIL bp_head got=%h exp=11", mem_alu_data); end
    mem_ready = 1'b1;
    for (int i = 0; i < 10 && got.size() < 3; i++) begin
      acc = ex_valid && ex_ready;
      if (mem_valid) got.push_back(mem_alu_data);
      tick();
      if (acc) ex_valid = 1'b0;
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count got=%0d exp=3 (cycle budget)", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== want[i]) begin errors++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got[i], want[i]); end
    end
    checks++; if (retire_count !== 4'(m_cnt)) begin errors++; $display("FAIL bp_retire got=%0d exp=%0d", retire_count, m_cnt); end
    drive('0, 1'b0);
  endtask

  task automatic test_flush();
    logic [3:0] saved;
    mem_ready = 1'b0;
    drive(rnd_ent(), 1'b1); tick();
    drive(rnd_ent(), 1'b1); tick();
    saved = retire_count;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
    flush = 1'b1; mem_ready = 1'b1;
    drive(mk(32'h99, $urandom, 1'b0, 1'b0), 1'b1);
    tick();
    flush = 1'b0;
    drive('0, 1'b0);
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", mem_valid); end
    checks++; if (retire_count !== saved) begin errors++; $display("FAIL flush_retire got=%0d exp=%0d", retire_count, saved); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got=%0b exp=0 alu=%h", mem_valid, mem_alu_data); end
    end
    $display("[%0t] flush done", $time);
  endtask

  task automatic test_ovf_sticky();
    mem_ready = 1'b0;
    drive(mk(32'h5, 32'h6, 1'b1, 1'b0), 1'b1); tick();
    drive('0, 1'b0);
    mem_ready = 1'b1; ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%0b exp=1", ovf_sticky); end
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b exp=0", ovf_sticky); end
    drive(mk(32'h7, 32'h8, 1'b1, 1'b0), 1'b1); tick();
    drive('0, 1'b0); tick();
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_reset got=%0b exp=1", ovf_sticky); end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_flush_keep got=%0b exp=1", ovf_sticky); end
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
  endtask

  task automatic test_counter_wrap();
    rst = 1'b1; tick(); rst = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(rnd_ent(), 1'b1); tick();
      drive('0, 1'b0); tick();
    end
    checks++; if (retire_count !== 4'd1) begin errors++; $display("FAIL wrap_retire got=%0d exp=1", retire_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(rnd_ent(), 1'($urandom_range(0, 3) != 0));
      mem_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 24) == 0);
      ovf_clear = 1'($urandom_range(0, 9) == 0);
      checks++; if (mem_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", i, mem_valid, mq.size() != 0); end
      checks++; if (ex_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", i, ex_ready, mq.size() < DEPTH); end
      checks++; if (occupancy !== 2'(mq.size())) begin errors++; $display("FAIL rnd_occ[%0d] got=%0d exp=%0d", i, occupancy, mq.size()); end
      checks++; if (dut_head !== 75'(exp_head())) begin errors++; $display("FAIL rnd_head[%0d] got=%h exp=%h", i, dut_head, exp_head()); end
      checks++; if (retire_count !== 4'(m_cnt)) begin errors++; $display("FAIL rnd_retire[%0d] got=%0d exp=%0d", i, retire_count, m_cnt); end
      checks++; if (ovf_sticky !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d] got=%0b exp=%0b", i, ovf_sticky, m_ovf); end
      tick();
    end
    flush = 1'b0; ovf_clear = 1'b0;
    drive('0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; mem_ready = 1'b0; ovf_clear = 1'b0;
    drive('0, 1'b0);
    test_reset();
    test_single();
    test_backpressure();
    test_flush();
    test_ovf_sticky();
    test_counter_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
